// File: rtl/id_issue_scoreboard.sv
// Issue controller: decodes register usage, tracks in-flight writes in a 32-bit scoreboard and gates issue.
// Optional `WB_BYPASS_EN lets a register being written back this cycle issue in the same cycle.
module id_issue_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             issue_valid,
  input  logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] outstanding,
  output logic             wb_err
);

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        uses_rs1, uses_rs2, writes_rd;
  logic [31:0] wb_hit, set_hit, clr_hit, busy_eff;
  logic        hazard, full, at_max, fire, set_any, wb_clear, wb_bad;
  logic        unused_bits;

  assign opcode      = instruction[6:0];
  assign rd          = instruction[11:7];
  assign rs1         = instruction[19:15];
  assign rs2         = instruction[24:20];
  assign unused_bits = ^{instruction[31:25], instruction[14:12]};

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      7'b0010011,
      7'b0000011,
      7'b1100111: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      7'b0100011,
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1101111,
      7'b0110111,
      7'b0010111: writes_rd = 1'b1;
      default:    ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  // Per-register one-hot views of the writeback and the issuing destination; x0 never hits.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_hit
      if (gi == 0) begin : g_zero
        assign wb_hit[gi]  = 1'b0;
        assign set_hit[gi] = 1'b0;
      end else begin : g_reg
        assign wb_hit[gi]  = wb_valid && (wb_rd == 5'(gi));
        assign set_hit[gi] = set_any && (rd == 5'(gi));
      end
    end
  endgenerate

  assign clr_hit  = wb_hit & busy_mask;
  assign wb_clear = |clr_hit;
  assign wb_bad   = |(wb_hit & ~busy_mask);
  assign at_max   = (outstanding == CNT_W'(MAX_OUTSTANDING));

`ifdef WB_BYPASS_EN
  // Register file writes before read, so a same-cycle writeback resolves the hazard.
  assign busy_eff = busy_mask & ~wb_hit;
  assign full     = writes_rd & at_max & ~wb_clear;
`else
  assign busy_eff = busy_mask;
  assign full     = writes_rd & at_max;
`endif

  assign hazard = (uses_rs1 & busy_eff[rs1]) | (uses_rs2 & busy_eff[rs2]) | (writes_rd & busy_eff[rd]);

  assign issue_valid = rst_n & in_valid & ~hazard & ~full & ~flush;
  assign in_ready    = issue_valid & issue_ready;
  assign stall       = rst_n & in_valid & (hazard | full) & ~flush;
  assign fire        = in_valid & in_ready;
  assign set_any     = fire & writes_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask   <= '0;
      outstanding <= '0;
      wb_err      <= 1'b0;
    end else if (flush) begin
      busy_mask   <= '0;
      outstanding <= '0;
    end else begin
      // A set on the same register as a clear wins, leaving the bit busy.
      busy_mask <= (busy_mask & ~clr_hit) | set_hit;
      if (set_any && !wb_clear)
        outstanding <= outstanding + CNT_W'(1);
      else if (!set_any && wb_clear)
        outstanding <= outstanding - CNT_W'(1);
      if (wb_bad) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Bench for id_issue_scoreboard: an opcode-table reference model queues expected outputs per step.
// Honours `WB_BYPASS_EN the same way as the design.
module tb_id_issue_scoreboard;
  localparam int MAX   = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic             issue_valid;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic             stall;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] outstanding;
  logic             wb_err;

  id_issue_scoreboard #(.MAX_OUTSTANDING(MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall),
    .busy_mask(busy_mask), .outstanding(outstanding), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        iv, ir, st;
    logic [31:0] busy;
    int          outs;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_busy;
  int          m_out;
  logic        m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] addi(input int r);
    return 32'h0010_0013 | (32'(r) << 7);
  endfunction

  // Applies one cycle of stimulus, checks combinational outputs and pre-edge state, then advances the model.
  task automatic step(input string tag, input logic [31:0] ins, input logic v, input logic rdy,
                      input logic wv, input logic [4:0] wr, input logic fl);
    logic u1, u2, w, hz, fu, iv, ir, clr, bad;
    logic [31:0] bm;
    logic [4:0] rd, r1, r2;
    exp_t e, got;
    @(negedge clk);
    instruction = ins; in_valid = v; issue_ready = rdy; wb_valid = wv; wb_rd = wr; flush = fl;
    rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20];
    {u1, u2, w} = 3'b000;
    case (ins[6:0])
      7'b0110011: {u1, u2, w} = 3'b111;
      7'b0010011: {u1, u2, w} = 3'b101;
      7'b0000011: {u1, u2, w} = 3'b101;
      7'b0100011: {u1, u2, w} = 3'b110;
      7'b1100011: {u1, u2, w} = 3'b110;
      7'b1100111: {u1, u2, w} = 3'b101;
      7'b1101111: {u1, u2, w} = 3'b001;
      7'b0110111: {u1, u2, w} = 3'b001;
      7'b0010111: {u1, u2, w} = 3'b001;
      default:    {u1, u2, w} = 3'b000;
    endcase
    if (rd == 0) w = 1'b0;
    clr = wv && wr != 0 && m_busy[wr];
    bad = wv && wr != 0 && !m_busy[wr];
    bm  = m_busy;
    fu  = w && (m_out == MAX);
`ifdef WB_BYPASS_EN
    if (wv) bm[wr] = 1'b0;
    if (clr) fu = 1'b0;
`endif
    hz = (u1 && r1 != 0 && bm[r1]) || (u2 && r2 != 0 && bm[r2]) || (w && bm[rd]);
    iv = v && !hz && !fu && !fl;
    ir = iv && rdy;
    e.tag = tag; e.iv = iv; e.ir = ir; e.st = v && (hz || fu) && !fl;
    e.busy = m_busy; e.outs = m_out; e.err = m_err;
    exp_q.push_back(e);
    #2;
    got = exp_q.pop_front();
    $display("txn %-10s ins=%08h v=%0b wb=%0b/%0d fl=%0b -> iv=%0b ir=%0b st=%0b busy=%08h out=%0d err=%0b",
             got.tag, ins, v, wv, wr, fl, issue_valid, in_ready, stall, busy_mask, outstanding, wb_err);
    check_val({got.tag, ".issue_valid"}, 32'(issue_valid), 32'(got.iv));
    check_val({got.tag, ".in_ready"},    32'(in_ready),    32'(got.ir));
    check_val({got.tag, ".stall"},       32'(stall),       32'(got.st));
    check_val({got.tag, ".busy_mask"},   busy_mask,        got.busy);
    check_val({got.tag, ".outstanding"}, 32'(outstanding), 32'(got.outs));
    check_val({got.tag, ".wb_err"},      32'(wb_err),      32'(got.err));
    if (fl) begin
      m_busy = '0; m_out = 0;
    end else begin
      if (clr) begin m_busy[wr] = 1'b0; m_out--; end
      if (ir && w) begin m_busy[rd] = 1'b1; m_out++; end
      if (bad) m_err = 1'b1;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; issue_ready = 1'b1; instruction = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    m_busy = '0; m_out = 0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst");

    // Asynchronous reset mid-run while x5 is busy
    step("add_x5", 32'h0020_82B3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #1 check_val("pre_rst.busy", busy_mask, 32'h0000_0020);
    instruction = addi(7); in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_val("arst.busy", busy_mask, 32'h0);
    check_val("arst.outs", 32'(outstanding), 32'h0);
    check_val("arst.err", 32'(wb_err), 32'h0);
    check_val("arst.issue_valid", 32'(issue_valid), 32'h0);
    check_val("arst.stall", 32'(stall), 32'h0);
    m_busy = '0; m_out = 0; m_err = 1'b0;
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b1;

    // RAW: sub x6,x5,x3 waits for writeback of x5
    step("raw_add", 32'h0020_82B3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("raw_sub0", 32'h4032_8333, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("raw_sub1", 32'h4032_8333, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("raw_wb5", 32'h4032_8333, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
`ifndef WB_BYPASS_EN
    step("raw_sub2", 32'h4032_8333, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
`endif
    step("flush0", 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
    idle("clean0");

    // Full counter
    for (int r = 1; r <= 4; r++) step($sformatf("fill_x%0d", r), addi(r), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    #1 check_val("full.outs", 32'(outstanding), 32'd4);
    step("full_x7", addi(7), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("full_sw", 32'h0010_A023, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("full_wb1", addi(7), 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
`ifndef WB_BYPASS_EN
    step("full_x7b", addi(7), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
`endif

    // Flush with a same-cycle writeback: ignored, so no error even if x1 is already clear
    step("flush_wb", 32'h0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1);
    @(negedge clk);
    #1;
    check_val("flush.busy", busy_mask, 32'h0);
    check_val("flush.outs", 32'(outstanding), 32'h0);
    check_val("flush.err", 32'(wb_err), 32'h0);

    // Backpressure
    step("bp", addi(7), 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    idle("bp_after");

    // Bad writeback, x0 destination, unknown opcode, wb to x0
    step("bad_wb9", 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    idle("sticky");
    step("busy_x2", addi(2), 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("addi_x0", 32'h0000_0013, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("fence", 32'h0010_000F, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    step("sw_raw", 32'h0010_A023, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("jal_x2", 32'h0000_016F, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("same_wb", addi(3), 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);

    // Randomised traffic over a small register set
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: ins = addi($urandom_range(0, 6)) | (32'($urandom_range(0, 6)) << 15);
        1: ins = 32'h0000_0033 | (32'($urandom_range(0, 6)) << 7) | (32'($urandom_range(0, 6)) << 15)
                 | (32'($urandom_range(0, 6)) << 20);
        2: ins = 32'h0000_0023 | (32'($urandom_range(0, 6)) << 15) | (32'($urandom_range(0, 6)) << 20);
        default: ins = 32'h0000_0037 | (32'($urandom_range(0, 6)) << 7);
      endcase
      step($sformatf("rnd%0d", i), ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), 1'($urandom_range(0, 15) == 0));
    end
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
